mole_controller: RTL and testbench

Mole-generation and hit-detection stage driven by the game control FSM. While `enable` is high it lights one mole LED at a pseudo-random position for a window set by `difficulty_level`. It reports each whack as `hit_pulse`, each expiry as `timeout_pulse` and each wrong-button press as `miss_pulse`. `hit_pulse` and `timeout_pulse` feed the control FSM and the score counter.

---
 rtl/mole_controller.sv | 148 ++++++++++++++
 tb/tb_mole_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_controller.sv
// Mole generation and hit detection.
// Lights one pseudo-random mole per window and reports hit/timeout/miss.
module mole_controller #(
    parameter int NUM_MOLES   = 8,
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int GAP_MS      = 300
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [1:0]                   difficulty_level,
    input  logic [NUM_MOLES-1:0]         btn_mole,
    output logic [NUM_MOLES-1:0]         mole_leds,
    output logic [$clog2(NUM_MOLES)-1:0] active_idx,
    output logic                         hit_pulse,
    output logic                         timeout_pulse,
    output logic                         miss_pulse
);

    localparam int IDX_W  = $clog2(NUM_MOLES);
    localparam int TPM    = CLK_FREQ_HZ / 1000;
    localparam int PRE_W  = $clog2(TPM + 1);
    localparam int MS_MAX = (GAP_MS > 1500) ? GAP_MS : 1500;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SHOW
    } state_t;

    state_t state_q, state_d;

    logic [PRE_W-1:0]     pre_q;
    logic [MS_W-1:0]      ms_q;
    logic [MS_W-1:0]      win_q;
    logic [MS_W-1:0]      win_d;
    logic [15:0]          lfsr_q;
    logic [NUM_MOLES-1:0] btn_prev;
    logic [NUM_MOLES-1:0] btn_rise;
    logic [NUM_MOLES-1:0] target;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     next_idx;
    logic [IDX_W-1:0]     show_idx;
    logic                 ms_tick;
    logic                 gap_done;
    logic                 win_done;
    logic                 hit_d;
    logic                 timeout_d;
    logic                 miss_d;
    logic                 load;

    assign ms_tick  = (pre_q == PRE_W'(TPM - 1));
    assign gap_done = ms_tick && (ms_q == MS_W'(GAP_MS - 1));
    assign win_done = ms_tick && (ms_q == win_q - MS_W'(1));
    assign btn_rise = btn_mole & ~btn_prev;
    assign target   = NUM_MOLES'(1) << active_idx;

    // New mole index avoids repeating the previous position.
    assign pick     = lfsr_q[IDX_W-1:0];
    assign next_idx = (pick == active_idx) ? pick + IDX_W'(1) : pick;
    assign show_idx = load ? next_idx : active_idx;

    // Window length sampled at SHOW entry.
    always_comb begin
        win_d = MS_W'(600);
        unique case (difficulty_level)
            2'b00:   win_d = MS_W'(1500);
            2'b01:   win_d = MS_W'(1000);
            default: win_d = MS_W'(600);
        endcase
    end

    // Next-state and strobe decode; hit outranks expiry and misses.
    always_comb begin
        state_d   = state_q;
        hit_d     = 1'b0;
        timeout_d = 1'b0;
        miss_d    = 1'b0;
        load      = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_GAP;
                S_GAP: begin
                    if (gap_done) begin
                        state_d = S_SHOW;
                        load    = 1'b1;
                    end
                end
                S_SHOW: begin
                    if (|(btn_rise & target)) begin
                        hit_d   = 1'b1;
                        state_d = S_GAP;
                    end else if (win_done) begin
                        timeout_d = 1'b1;
                        state_d   = S_GAP;
                    end else if (|(btn_rise & ~target)) begin
                        miss_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, timers, LFSR and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pre_q         <= '0;
            ms_q          <= '0;
            win_q         <= '0;
            lfsr_q        <= 16'hACE1;
            btn_prev      <= '0;
            active_idx    <= '0;
            mole_leds     <= '0;
            hit_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
            miss_pulse    <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_prev <= btn_mole;
            lfsr_q   <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                         lfsr_q[15:1]};
            if (state_d != state_q || state_q == S_IDLE) begin
                pre_q <= '0;
                ms_q  <= '0;
            end else if (ms_tick) begin
                pre_q <= '0;
                ms_q  <= ms_q + MS_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
            if (load) begin
                active_idx <= next_idx;
                win_q      <= win_d;
            end
            mole_leds     <= (state_d == S_SHOW) ?
                             (NUM_MOLES'(1) << show_idx) : '0;
            hit_pulse     <= hit_d;
            timeout_pulse <= timeout_d;
            miss_pulse    <= miss_d;
        end
    end

endmodule

// File: tb/tb_mole_controller.sv
// Scoreboard bench for mole_controller.
// Stimulus queues expected events; a monitor matches them as they appear.
module tb_mole_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] difficulty_level;
    logic [7:0] btn_mole;
    logic [7:0] mole_leds;
    logic [2:0] active_idx;
    logic       hit_pulse;
    logic       timeout_pulse;
    logic       miss_pulse;

    int total  = 0;
    int passed = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [2:0] strb;
        logic [7:0] leds;
        logic [2:0] idx;
    } ev_t;

    ev_t q[$];

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] HIT  = 3'b100;
    localparam logic [2:0] TO   = 3'b010;
    localparam logic [2:0] MISS = 3'b001;

    mole_controller #(
        .NUM_MOLES(8),
        .CLK_FREQ_HZ(10_000),
        .GAP_MS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .difficulty_level(difficulty_level),
        .btn_mole(btn_mole),
        .mole_leds(mole_leds),
        .active_idx(active_idx),
        .hit_pulse(hit_pulse),
        .timeout_pulse(timeout_pulse),
        .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; LFSR state equals ACE1 stepped cyc times.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr_at(int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++)
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        return l;
    endfunction

    function automatic logic [2:0] pick(int n, logic [2:0] prev);
        logic [15:0] l;
        logic [2:0]  p;
        l = lfsr_at(n);
        p = l[2:0];
        if (p == prev) p = p + 3'd1;
        return p;
    endfunction

    function automatic logic [7:0] oh(logic [2:0] i);
        return 8'b1 << i;
    endfunction

    task automatic push(int c, logic [2:0] s, logic [7:0] l, logic [2:0] i);
        ev_t e;
        e.cyc  = c;
        e.strb = s;
        e.leds = l;
        e.idx  = i;
        q.push_back(e);
    endtask

    task automatic at_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_leds"}, int'(mole_leds), 0);
        chk({tag, "_idx"}, int'(active_idx), 0);
        chk({tag, "_strb"},
            int'({hit_pulse, timeout_pulse, miss_pulse}), 0);
    endtask

    // Monitor: any strobe or LED change is an event to match.
    logic [7:0] prev_leds;
    always @(negedge clk) begin
        ev_t        e;
        logic [2:0] s;
        if (!rst_n) begin
            prev_leds = '0;
        end else begin
            s = {hit_pulse, timeout_pulse, miss_pulse};
            if (s != NONE || mole_leds != prev_leds) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_event: cyc %0d strb %b leds %b",
                             cyc, s, mole_leds);
                end else begin
                    e = q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_strobes", int'(s), int'(e.strb));
                    chk("ev_leds", int'(mole_leds), int'(e.leds));
                    chk("ev_idx", int'(active_idx), int'(e.idx));
                end
            end
            prev_leds = mole_leds;
        end
    end

    initial begin
        int         g;
        int         s;
        logic [2:0] idx;
        logic [2:0] prev;
        logic [2:0] w;
        rst_n            = 1'b0;
        enable           = 1'b0;
        difficulty_level = 2'b00;
        btn_mole         = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Easy mole runs to timeout.
        at_cyc(2);
        enable = 1'b1;
        g = 3;
        s = g + 30;
        idx = pick(g + 29, 3'd0);
        push(s, NONE, oh(idx), idx);
        push(s + 15000, TO, 8'h00, idx);
        prev = idx;
        at_cyc(s + 100);
        difficulty_level = 2'b10;

        // Hard mole whacked 50 cycles in.
        g = s + 15000;
        s = g + 30;
        idx = pick(g + 29, prev);
        push(s, NONE, oh(idx), idx);
        prev = idx;
        at_cyc(s + 50);
        btn_mole[idx] = 1'b1;
        push(s + 51, HIT, 8'h00, idx);
        at_cyc(s + 52);
        btn_mole = '0;
        difficulty_level = 2'b01;

        // Medium mole: wrong button, then timeout.
        g = s + 51;
        s = g + 30;
        idx = pick(g + 29, prev);
        push(s, NONE, oh(idx), idx);
        prev = idx;
        at_cyc(s + 500);
        w = idx + 3'd1;
        btn_mole[w] = 1'b1;
        push(s + 501, MISS, oh(idx), idx);
        at_cyc(s + 510);
        btn_mole = '0;
        push(s + 10000, TO, 8'h00, idx);
        difficulty_level = 2'b10;

        // Hit on the final window cycle beats expiry.
        g = s + 10000;
        s = g + 30;
        idx = pick(g + 29, prev);
        push(s, NONE, oh(idx), idx);
        prev = idx;
        at_cyc(s + 5999);
        btn_mole[idx] = 1'b1;
        push(s + 6000, HIT, 8'h00, idx);
        at_cyc(s + 6002);
        btn_mole = '0;

        // Target held since before SHOW never counts.
        g = s + 6000;
        s = g + 30;
        idx = pick(g + 29, prev);
        push(s, NONE, oh(idx), idx);
        prev = idx;
        at_cyc(s - 5);
        btn_mole[idx] = 1'b1;
        push(s + 6000, TO, 8'h00, idx);
        at_cyc(s + 6010);
        btn_mole = '0;

        // Enable drop mid-SHOW, then reset during GAP.
        g = s + 6000;
        s = g + 30;
        idx = pick(g + 29, prev);
        push(s, NONE, oh(idx), idx);
        at_cyc(s + 20);
        enable = 1'b0;
        push(s + 21, NONE, 8'h00, idx);
        at_cyc(s + 25);
        enable = 1'b1;
        at_cyc(s + 35);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Same first mole as after power-up shows the LFSR reseeded.
        at_cyc(2);
        enable = 1'b1;
        difficulty_level = 2'b00;
        idx = pick(32, 3'd0);
        push(33, NONE, oh(idx), idx);
        at_cyc(40);
        enable = 1'b0;
        push(41, NONE, 8'h00, idx);
        at_cyc(60);
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
